// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM burst controller: default widths and FSM state encoding.
package sram_ctrl_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;
    localparam int CNT_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/sram_burst_ctrl.sv
// Burst controller in front of a single-port SRAM with a registered read port.
// Accepts one write or read burst (1..8 beats) at a time; addresses wrap at the top.
module sram_burst_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [CNT_W-1:0]  cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_last,
    output logic              busy,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    // Handshake: a command transfers on a cycle where cmd_valid && cmd_ready;
    // a write beat transfers where wdata_valid && wdata_ready. Read beats have no backpressure.

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic              rdata_last_q, rdata_last_d;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        rdata_valid_d = 1'b0;
        rdata_last_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    cnt_d   = cmd_len;
                    state_d = cmd_write ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (wdata_valid) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_READ: begin
                // One address per cycle; the flagged beat emerges a cycle later with mem_dout.
                addr_d        = addr_q + ADDR_W'(1);
                rdata_valid_d = 1'b1;
                rdata_last_d  = (cnt_q == '0);
                if (cnt_q == '0) begin
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            cnt_q         <= '0;
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            rdata_valid_q <= rdata_valid_d;
            rdata_last_q  <= rdata_last_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign wdata_ready = (state_q == ST_WRITE);
    assign mem_wr_en   = (state_q == ST_WRITE) && wdata_valid;
    assign mem_addr    = addr_q;
    assign mem_din     = wdata;
    assign rdata_valid = rdata_valid_q;
    assign rdata_last  = rdata_last_q;
    assign rdata       = mem_dout;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Bench for sram_burst_ctrl with a behavioural SRAM beside it and a reference memory model.
module tb_sram_burst_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [2:0]    cmd_len;
    logic          wdata_valid, wdata_ready;
    logic [DW-1:0] wdata;
    logic          rdata_valid, rdata_last, busy;
    logic [DW-1:0] rdata;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] sram    [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] wbuf    [8];
    logic [DW-1:0] exp_q   [$];

    always #5 clk = ~clk;

    sram_burst_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
        .busy(busy), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // simple_sram: write-first not needed, read data registered one cycle after addr.
    always @(posedge clk) begin
        if (mem_wr_en) sram[mem_addr] <= mem_din;
        mem_dout <= sram[mem_addr];
    end

    function automatic logic [AW-1:0] wrap_addr(input logic [AW-1:0] a, input int k);
        return AW'((int'(a) + k) % DEPTH);
    endfunction

    task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [2:0] len,
                            output bit ok);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = len;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cmd_accept: cmd_ready never seen within 20 cycles (addr %0d len %0d)", a, len);
        end
    endtask

    task automatic write_beats(input logic [AW-1:0] a, input int n, input int stall_at,
                               input int stall_len);
        logic [AW-1:0] ea;
        for (int k = 0; k < n; k++) begin
            ea = wrap_addr(a, k);
            if (k == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    wdata_valid = 1'b0; wdata = DW'($urandom);
                    @(negedge clk);
                    checks++;
                    if ({mem_wr_en, mem_addr, wdata_ready, cmd_ready} !== {1'b0, ea, 1'b1, 1'b0}) begin
                        errors++;
                        $display("FAIL write_stall beat %0d: wr_en/addr/wready/cready got %b/%0d/%b/%b want 0/%0d/1/0",
                                 k, mem_wr_en, mem_addr, wdata_ready, cmd_ready, ea);
                    end
                    @(posedge clk); #1;
                end
            end
            wdata_valid = 1'b1; wdata = wbuf[k];
            @(negedge clk);
            checks++;
            if ({mem_wr_en, mem_addr, mem_din, wdata_ready, cmd_ready} !== {1'b1, ea, wbuf[k], 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL write_beat %0d: wr_en/addr/din/wready/cready got %b/%0d/%h/%b/%b want 1/%0d/%h/1/0",
                         k, mem_wr_en, mem_addr, mem_din, wdata_ready, cmd_ready, ea, wbuf[k]);
            end
            ref_mem[ea] = wbuf[k];
            @(posedge clk); #1;
        end
        wdata_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [AW-1:0] a, input logic [2:0] len,
                               input int stall_at, input int stall_len);
        bit ok;
        send_cmd(1'b1, a, len, ok);
        if (!ok) return;
        write_beats(a, int'(len) + 1, stall_at, stall_len);
        @(negedge clk);
        checks++;
        if ({busy, cmd_ready, mem_wr_en} !== 3'b010) begin
            errors++;
            $display("FAIL write_end: busy/cready/wr_en got %b/%b/%b want 0/1/0", busy, cmd_ready, mem_wr_en);
        end
        @(posedge clk); #1;
    endtask

    task automatic read_burst(input logic [AW-1:0] a, input logic [2:0] len, input bit poke);
        bit ok;
        logic [DW-1:0] exp_d;
        send_cmd(1'b0, a, len, ok);
        if (!ok) return;
        for (int k = 0; k <= int'(len); k++) exp_q.push_back(ref_mem[wrap_addr(a, k)]);
        for (int c = 0; c <= int'(len) + 1; c++) begin
            if (poke) begin
                wdata_valid = 1'($urandom_range(0, 1)); wdata = DW'($urandom);
            end
            @(negedge clk);
            checks++;
            if ({mem_wr_en, wdata_ready, busy, cmd_ready} !== 4'b0010) begin
                errors++;
                $display("FAIL read_ctrl cycle %0d: wr_en/wready/busy/cready got %b/%b/%b/%b want 0/0/1/0",
                         c, mem_wr_en, wdata_ready, busy, cmd_ready);
            end
            if (c <= int'(len)) begin
                checks++;
                if (mem_addr !== wrap_addr(a, c)) begin
                    errors++;
                    $display("FAIL read_addr cycle %0d: got %0d want %0d", c, mem_addr, wrap_addr(a, c));
                end
            end
            if (c == 0) begin
                checks++;
                if (rdata_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL read_latency: rdata_valid got %b want 0 on issue cycle", rdata_valid);
                end
            end else begin
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                checks++;
                if ({rdata_valid, rdata_last, rdata} !== {1'b1, (c - 1 == int'(len)), exp_d}) begin
                    errors++;
                    $display("FAIL read_beat %0d: valid/last/data got %b/%b/%h want 1/%b/%h",
                             c - 1, rdata_valid, rdata_last, rdata, (c - 1 == int'(len)), exp_d);
                end
            end
            @(posedge clk); #1;
        end
        wdata_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, rdata_valid, rdata_last, cmd_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL read_end: busy/rvalid/rlast/cready got %b/%b/%b/%b want 0/0/0/1",
                     busy, rdata_valid, rdata_last, cmd_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({cmd_ready, busy, mem_wr_en, mem_addr, rdata_valid, rdata_last, wdata_ready}
            !== {1'b1, 1'b0, 1'b0, AW'(0), 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s: cready/busy/wr_en/addr/rvalid/rlast/wready got %b/%b/%b/%0d/%b/%b/%b want 1/0/0/0/0/0/0",
                     tag, cmd_ready, busy, mem_wr_en, mem_addr, rdata_valid, rdata_last, wdata_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd5; cmd_len = 3'd2;
        wdata_valid = 1'b1; wdata = 8'hAA;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_hold");
        #1 cmd_valid = 1'b0; wdata_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_release");
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        wbuf[0] = 8'hF0;
        write_burst(3'd3, 3'd0, -1, 0);
        read_burst(3'd3, 3'd0, 1'b0);
    endtask

    task automatic test_wrap();
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        write_burst(3'd6, 3'd3, -1, 0);
        read_burst(3'd6, 3'd3, 1'b0);
    endtask

    task automatic test_stall();
        for (int k = 0; k < 4; k++) wbuf[k] = DW'($urandom);
        write_burst(3'd1, 3'd3, 2, 2);
        read_burst(3'd1, 3'd3, 1'b0);
    endtask

    task automatic test_ignored();
        bit ok;
        for (int k = 0; k < 3; k++) wbuf[k] = DW'($urandom);
        send_cmd(1'b1, 3'd4, 3'd2, ok);
        if (!ok) return;
        // Second command stays offered for the whole write burst.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd4; cmd_len = 3'd2;
        write_beats(3'd4, 3, -1, 0);
        read_burst(3'd4, 3'd2, 1'b1);
    endtask

    task automatic test_reset_mid();
        bit ok;
        for (int k = 0; k < 8; k++) wbuf[k] = DW'($urandom);
        write_burst(3'd0, 3'd7, -1, 0);
        for (int k = 0; k < 8; k++) wbuf[k] = ~ref_mem[k];
        send_cmd(1'b1, 3'd0, 3'd7, ok);
        if (!ok) return;
        write_beats(3'd0, 3, -1, 0);
        wdata_valid = 1'b1; wdata = wbuf[3];
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_assert");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_mid_hold");
        @(posedge clk); #1 rst_n = 1'b1; wdata_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_mid_release");
        @(posedge clk); #1;
        read_burst(3'd0, 3'd7, 1'b0);
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [2:0]    len;
        for (int it = 0; it < 8; it++) begin
            a   = AW'($urandom_range(0, DEPTH - 1));
            len = 3'($urandom_range(0, 7));
            for (int k = 0; k < 8; k++) wbuf[k] = DW'($urandom);
            write_burst(a, len, $urandom_range(0, int'(len)), $urandom_range(0, 2));
            read_burst(AW'($urandom_range(0, DEPTH - 1)), 3'($urandom_range(0, 7)), 1'b1);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata_valid = 1'b0; wdata = '0;
        test_reset();
        test_single();
        test_wrap();
        test_stall();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
